// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the vector display frame sequencer: point-word
// field layout, sequencer state encoding and default timing constants.
package vector_pkg;

    // Point word layout as delivered by the point buffer
    localparam int PT_W     = 25;
    localparam int BEAM_BIT = 24;
    localparam int X_HI     = 23;
    localparam int X_LO     = 12;
    localparam int Y_HI     = 11;
    localparam int Y_LO     = 0;

    // Default geometry and timing
    localparam int DEF_ADDR_W     = 11;
    localparam int DEF_COORD_W    = 12;
    localparam int DEF_OFF_SETTLE = 16;
    localparam int DEF_ON_SETTLE  = 4;
    localparam int DEF_MIN_FRAME  = 200000;
    localparam int DEF_WDOG       = 65535;

    // Internal counter widths
    localparam int TIMER_W  = 24;
    localparam int SETTLE_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LATCH,
        WAIT_RDY,
        OFF_WAIT,
        ON_WAIT,
        ISSUE,
        FRAME_END,
        HOLDOFF
    } seq_state_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Drawer-side handshake: target coordinates, draw strobe, beam enable out
// to the DAC controller and its ready indication back.
interface frame_sequencer_if
    import vector_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               draw;
    logic               beam;
    logic               ready;

    modport master (output x, output y, output draw, output beam, input ready);
    modport slave  (input x, input y, input draw, input beam, output ready);
endinterface

// File: rtl/frame_sequencer_beam_watchdog.sv
// Counts consecutive cycles the beam is lit while the drawer is stalled and
// raises a sticky fault when the limit is hit, protecting the phosphor.
module beam_watchdog
    import vector_pkg::*;
#(
    parameter int WDOG = DEF_WDOG
) (
    input  logic clk,
    input  logic reset,
    input  logic beam,
    input  logic ready,
    output logic trip,
    output logic fault
);
    localparam int WD_W = $clog2(WDOG + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);

    logic [WD_W-1:0] count;

    // trip fires during the WDOG-th consecutive stalled lit cycle so the
    // sequencer can kill the beam on the same edge the fault is latched
    assign trip = beam && !ready && (count == WD_LAST);

    // stall counter restarts whenever the beam is dark or the drawer moves
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            fault <= 1'b0;
        end else begin
            fault <= fault | trip;
            if (beam && !ready && !trip) count <= count + 1'b1;
            else                         count <= '0;
        end
    end
endmodule

// File: rtl/frame_sequencer.sv
// Walks one frame of points from the point buffer, issues one draw per point
// to the DAC controller, settles the beam around blanked moves, enforces a
// minimum frame period and cuts the beam on a drawer stall.
module frame_sequencer
    import vector_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int OFF_SETTLE = DEF_OFF_SETTLE,
    parameter int ON_SETTLE  = DEF_ON_SETTLE,
    parameter int MIN_FRAME  = DEF_MIN_FRAME,
    parameter int WDOG       = DEF_WDOG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_ready,
    input  logic [ADDR_W-1:0] num_pts,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PT_W-1:0]   rd_data,
    output logic              frame_done,
    output logic              busy,
    output logic              fault,
    frame_sequencer_if.master dac
);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(MIN_FRAME - 1);

    seq_state_t          state, next_state;
    logic [ADDR_W-1:0]   ptr, next_ptr;
    logic [ADDR_W-1:0]   num_q, next_num;
    logic [ADDR_W-1:0]   next_rd_addr;
    logic [PT_W-1:0]     pt, next_pt;
    logic [COORD_W-1:0]  x_q, next_x;
    logic [COORD_W-1:0]  y_q, next_y;
    logic                beam_q, next_beam;
    logic                next_busy;
    logic                next_frame_done;
    logic [TIMER_W-1:0]  timer, next_timer;
    logic [SETTLE_W-1:0] settle, next_settle;
    logic [ADDR_W-1:0]   ptr_inc;
    logic                trip;

    assign ptr_inc  = ptr + ADDR_W'(1);
    assign dac.x    = x_q;
    assign dac.y    = y_q;
    assign dac.beam = beam_q;
    assign dac.draw = (state == ISSUE);

    beam_watchdog #(.WDOG(WDOG)) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .beam  (beam_q),
        .ready (dac.ready),
        .trip  (trip),
        .fault (fault)
    );

    // state and datapath registers; reset drops the beam on the next edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            num_q      <= '0;
            rd_addr    <= '0;
            pt         <= '0;
            x_q        <= '0;
            y_q        <= '0;
            beam_q     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            timer      <= '0;
            settle     <= '0;
        end else begin
            state      <= next_state;
            ptr        <= next_ptr;
            num_q      <= next_num;
            rd_addr    <= next_rd_addr;
            pt         <= next_pt;
            x_q        <= next_x;
            y_q        <= next_y;
            beam_q     <= next_beam;
            busy       <= next_busy;
            frame_done <= next_frame_done;
            timer      <= next_timer;
            settle     <= next_settle;
        end
    end

    // next-state logic: point walk, beam settling, frame holdoff, stall abort
    always_comb begin
        next_state      = state;
        next_ptr        = ptr;
        next_num        = num_q;
        next_rd_addr    = rd_addr;
        next_pt         = pt;
        next_x          = x_q;
        next_y          = y_q;
        next_beam       = beam_q;
        next_busy       = busy;
        next_frame_done = 1'b0;
        next_settle     = settle;
        next_timer      = timer;

        if (state != IDLE && timer != {TIMER_W{1'b1}}) next_timer = timer + 1'b1;

        case (state)
            IDLE: begin
                next_beam = 1'b0;
                if (frame_ready && !fault) begin
                    next_num     = num_pts;
                    next_ptr     = '0;
                    next_rd_addr = '0;
                    next_timer   = '0;
                    next_busy    = 1'b1;
                    next_state   = (num_pts == '0) ? FRAME_END : FETCH;
                end
            end
            FETCH: next_state = LATCH;
            LATCH: begin
                next_pt    = rd_data;
                next_state = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (dac.ready) begin
                    if (!pt[BEAM_BIT] && beam_q) begin
                        next_beam   = 1'b0;
                        next_settle = SETTLE_W'(OFF_SETTLE);
                        next_state  = OFF_WAIT;
                    end else if (pt[BEAM_BIT] && !beam_q) begin
                        next_beam   = 1'b1;
                        next_settle = SETTLE_W'(ON_SETTLE);
                        next_state  = ON_WAIT;
                    end else begin
                        next_state = ISSUE;
                    end
                end
            end
            OFF_WAIT, ON_WAIT: begin
                if (settle != '0) next_settle = settle - 1'b1;
                if (settle <= SETTLE_W'(1)) next_state = ISSUE;
            end
            ISSUE: begin
                next_ptr     = ptr_inc;
                next_rd_addr = ptr_inc;
                next_state   = (ptr_inc == num_q) ? FRAME_END : FETCH;
            end
            FRAME_END: begin
                if (dac.ready) begin
                    next_beam       = 1'b0;
                    next_frame_done = 1'b1;
                    next_state      = HOLDOFF;
                end
            end
            HOLDOFF: begin
                next_beam = 1'b0;
                if (timer >= HOLD_LAST) begin
                    next_busy  = 1'b0;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        if (trip) begin
            next_state = IDLE;
            next_beam  = 1'b0;
            next_busy  = 1'b0;
        end

        if (next_state == ISSUE) begin
            next_x = COORD_W'(pt[X_HI:X_LO]);
            next_y = COORD_W'(pt[Y_HI:Y_LO]);
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// Directed self-checking bench for frame_sequencer: draw sequencing, beam
// settle timing, empty frames, frame period, watchdog and mid-frame reset.
module tb_frame_sequencer;
    import vector_pkg::*;

    localparam int ADDR_W  = 11;
    localparam int COORD_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_ready;
    logic              ready;
    logic [ADDR_W-1:0] num_pts;
    logic [ADDR_W-1:0] rd_addr;
    logic [PT_W-1:0]   rd_data;
    logic              frame_done;
    logic              busy;
    logic              fault;
    logic [PT_W-1:0]   mem [0:2047];

    int n_compared   = 0;
    int n_mismatched = 0;

    int   cyc = 0;
    int   n_draw = 0;
    int   n_done = 0;
    int   n_rise = 0;
    int   n_overlap = 0;
    int   draw_cyc [0:63];
    int   draw_x   [0:63];
    int   draw_y   [0:63];
    logic draw_beam [0:63];
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   done_cyc = 0;
    logic done_beam = 1'b0;
    int   last_start = 0;
    int   start_addr = 0;
    int   end_cyc = 0;
    logic prev_beam = 1'b0;
    logic prev_busy = 1'b0;

    int base_draw, base_done, base_rise, s1, s2;

    frame_sequencer_if #(.COORD_W(COORD_W)) dac ();
    assign dac.ready = ready;

    frame_sequencer #(
        .ADDR_W(ADDR_W), .COORD_W(COORD_W), .OFF_SETTLE(16), .ON_SETTLE(4),
        .MIN_FRAME(1000), .WDOG(50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_ready (frame_ready),
        .num_pts     (num_pts),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_done  (frame_done),
        .busy        (busy),
        .fault       (fault),
        .dac         (dac)
    );

    // free-running clock
    always #5 clk = ~clk;

    // point buffer model: data valid the cycle after the address changes
    always @(posedge clk) rd_data <= mem[rd_addr];

    // cycle counter used to timestamp events
    always @(posedge clk) cyc <= cyc + 1;

    // passive monitor recording draws, beam edges and frame boundaries
    always @(negedge clk) begin
        if (dac.draw === 1'b1) begin
            if (n_draw < 64) begin
                draw_cyc[n_draw]  = cyc;
                draw_x[n_draw]    = int'(dac.x);
                draw_y[n_draw]    = int'(dac.y);
                draw_beam[n_draw] = dac.beam;
            end
            n_draw++;
        end
        if (dac.beam === 1'b1 && !prev_beam) begin rise_cyc = cyc; n_rise++; end
        if (dac.beam === 1'b0 && prev_beam) fall_cyc = cyc;
        prev_beam = (dac.beam === 1'b1);
        if (frame_done === 1'b1) begin n_done++; done_cyc = cyc; done_beam = dac.beam; end
        if (frame_done === 1'b1 && dac.draw === 1'b1) n_overlap++;
        if (busy === 1'b1 && !prev_busy) begin last_start = cyc; start_addr = int'(rd_addr); end
        if (busy === 1'b0 && prev_busy) end_cyc = cyc;
        prev_busy = (busy === 1'b1);
    end

    function automatic logic [PT_W-1:0] pt_word(input logic b, input int px, input int py);
        logic [11:0] xs, ys;
        xs = 12'(px);
        ys = 12'(py);
        return {b, xs, ys};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_busy(input logic val, input int budget, input string tag);
        int n = 0;
        while (busy !== val && n < budget) begin step(1); n++; end
        check_output(tag, 32'(busy), 32'(val));
    endtask

    task automatic wait_draw(input int budget, input string tag);
        int n = 0;
        while (dac.draw !== 1'b1 && n < budget) begin step(1); n++; end
        check_output(tag, 32'(dac.draw), 32'd1);
    endtask

    task automatic wait_beam(input int budget, input string tag);
        int n = 0;
        while (dac.beam !== 1'b1 && n < budget) begin step(1); n++; end
        check_output(tag, 32'(dac.beam), 32'd1);
    endtask

    task automatic check_reset_values(input string pfx);
        check_output({pfx, "_rd_addr"},    32'(rd_addr),    32'd0);
        check_output({pfx, "_x"},          32'(dac.x),      32'd0);
        check_output({pfx, "_y"},          32'(dac.y),      32'd0);
        check_output({pfx, "_draw"},       32'(dac.draw),   32'd0);
        check_output({pfx, "_beam"},       32'(dac.beam),   32'd0);
        check_output({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
        check_output({pfx, "_busy"},       32'(busy),       32'd0);
        check_output({pfx, "_fault"},      32'(fault),      32'd0);
    endtask

    task automatic apply_stimulus(input int npts);
        num_pts     = ADDR_W'(npts);
        frame_ready = 1'b1;
    endtask

    // directed test sequence
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        reset = 1'b1; frame_ready = 1'b0; ready = 1'b1; num_pts = '0;
        step(3);
        check_reset_values("rst");
        reset = 1'b0;
        step(1);

        // three points: blanked move, then two lit segments
        mem[0] = pt_word(1'b0, 100, 200);
        mem[1] = pt_word(1'b1, 300, 200);
        mem[2] = pt_word(1'b1, 300, 400);
        base_draw = n_draw; base_done = n_done;
        apply_stimulus(3);
        wait_busy(1'b1, 10, "t1_start");
        frame_ready = 1'b0;
        num_pts = ADDR_W'(7);
        wait_busy(1'b0, 1200, "t1_end");
        step(2);
        check_output("t1_ndraw", 32'(n_draw - base_draw), 32'd3);
        check_output("t1_d0_lat", 32'(draw_cyc[base_draw] - last_start), 32'd3);
        check_output("t1_d0_x", 32'(draw_x[base_draw]), 32'd100);
        check_output("t1_d0_y", 32'(draw_y[base_draw]), 32'd200);
        check_output("t1_d0_beam", 32'(draw_beam[base_draw]), 32'd0);
        check_output("t1_d1_x", 32'(draw_x[base_draw+1]), 32'd300);
        check_output("t1_d1_y", 32'(draw_y[base_draw+1]), 32'd200);
        check_output("t1_on_settle", 32'(draw_cyc[base_draw+1] - rise_cyc), 32'd4);
        check_output("t1_d2_x", 32'(draw_x[base_draw+2]), 32'd300);
        check_output("t1_d2_y", 32'(draw_y[base_draw+2]), 32'd400);
        check_output("t1_spacing", 32'(draw_cyc[base_draw+2] - draw_cyc[base_draw+1]), 32'd4);
        check_output("t1_ndone", 32'(n_done - base_done), 32'd1);
        check_output("t1_done_lat", 32'(done_cyc - draw_cyc[base_draw+2]), 32'd2);
        check_output("t1_done_beam", 32'(done_beam), 32'd0);
        check_output("t1_busy_len", 32'(end_cyc - last_start), 32'd1000);

        // lit point followed by a blanked move
        mem[0] = pt_word(1'b1, 10, 20);
        mem[1] = pt_word(1'b0, 30, 40);
        base_draw = n_draw;
        apply_stimulus(2);
        wait_busy(1'b1, 10, "t2_start");
        frame_ready = 1'b0;
        wait_busy(1'b0, 1200, "t2_end");
        step(2);
        check_output("t2_ndraw", 32'(n_draw - base_draw), 32'd2);
        check_output("t2_d0_lat", 32'(draw_cyc[base_draw] - last_start), 32'd7);
        check_output("t2_d0_beam", 32'(draw_beam[base_draw]), 32'd1);
        check_output("t2_fall", 32'(fall_cyc - draw_cyc[base_draw]), 32'd4);
        check_output("t2_off_settle", 32'(draw_cyc[base_draw+1] - fall_cyc), 32'd16);
        check_output("t2_d1_beam", 32'(draw_beam[base_draw+1]), 32'd0);
        check_output("t2_d1_x", 32'(draw_x[base_draw+1]), 32'd30);
        check_output("t2_d1_y", 32'(draw_y[base_draw+1]), 32'd40);

        // empty frame
        base_draw = n_draw; base_done = n_done; base_rise = n_rise;
        apply_stimulus(0);
        wait_busy(1'b1, 10, "t3_start");
        frame_ready = 1'b0;
        wait_busy(1'b0, 1200, "t3_end");
        step(2);
        check_output("t3_ndraw", 32'(n_draw - base_draw), 32'd0);
        check_output("t3_ndone", 32'(n_done - base_done), 32'd1);
        check_output("t3_done_lat", 32'(done_cyc - last_start), 32'd1);
        check_output("t3_busy_len", 32'(end_cyc - last_start), 32'd1000);
        check_output("t3_no_rise", 32'(n_rise - base_rise), 32'd0);

        // back-to-back frames with frame_ready held high
        mem[0] = pt_word(1'b1, 1, 2);
        mem[1] = pt_word(1'b1, 3, 4);
        base_draw = n_draw;
        apply_stimulus(2);
        wait_busy(1'b1, 10, "t4_start");
        step(2);
        s1 = last_start;
        wait_busy(1'b0, 1200, "t4_busy_fall");
        wait_busy(1'b1, 5, "t4_restart");
        frame_ready = 1'b0;
        step(2);
        s2 = last_start;
        check_output("t4_period", 32'(s2 - s1), 32'd1001);
        check_output("t4_restart_addr", 32'(start_addr), 32'd0);
        wait_busy(1'b0, 1200, "t4_end");
        step(2);
        check_output("t4_ndraw", 32'(n_draw - base_draw), 32'd4);

        // drawer stalls with the beam lit
        mem[0] = pt_word(1'b1, 500, 600);
        mem[1] = pt_word(1'b1, 700, 800);
        base_draw = n_draw;
        apply_stimulus(2);
        wait_draw(20, "t5_first_draw");
        ready = 1'b0;
        step(49);
        check_output("t5_fault_early", 32'(fault), 32'd0);
        check_output("t5_beam_early", 32'(dac.beam), 32'd1);
        step(1);
        check_output("t5_fault", 32'(fault), 32'd1);
        check_output("t5_beam_cut", 32'(dac.beam), 32'd0);
        check_output("t5_busy_cut", 32'(busy), 32'd0);
        ready = 1'b1;
        step(30);
        check_output("t5_ndraw", 32'(n_draw - base_draw), 32'd1);
        check_output("t5_ignored", 32'(busy), 32'd0);
        check_output("t5_dark", 32'(dac.beam), 32'd0);
        check_output("t5_sticky", 32'(fault), 32'd1);
        reset = 1'b1; frame_ready = 1'b0;
        step(1);
        check_reset_values("t5_rst");
        reset = 1'b0;
        step(1);

        // reset while settling the beam on
        mem[0] = pt_word(1'b1, 11, 22);
        apply_stimulus(1);
        wait_beam(20, "t6_beam_on");
        step(1);
        base_draw = n_draw; base_done = n_done;
        reset = 1'b1;
        step(1);
        check_output("t6_beam", 32'(dac.beam), 32'd0);
        check_output("t6_draw", 32'(dac.draw), 32'd0);
        check_output("t6_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_busy(1'b1, 5, "t6_restart");
        check_output("t6_rd_addr", 32'(rd_addr), 32'd0);
        frame_ready = 1'b0;
        wait_draw(20, "t6_draw_seen");
        check_output("t6_x", 32'(dac.x), 32'd11);
        check_output("t6_y", 32'(dac.y), 32'd22);
        wait_busy(1'b0, 1200, "t6_end");
        step(2);
        check_output("t6_ndraw", 32'(n_draw - base_draw), 32'd1);
        check_output("t6_ndone", 32'(n_done - base_done), 32'd1);
        check_output("no_draw_done_overlap", 32'(n_overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
